mul_hilo_ctrl: RTL
==================

Name: mul_hilo_ctrl

Overview:
Multi-cycle control stage wrapped around the team's 32x32 combinational unsigned multiplier, which produces a 64-bit product.
- Accepts a start request with signed/unsigned selection.
- Registers the operand magnitudes that drive the multiplier.
- Holds them for LATENCY cycles so the long combinational path can settle.
- Sign-corrects the 64-bit product and commits it to architectural HI/LO registers.
- Also services MTHI/MTLO-style direct writes. Sits between the execute stage and the combinational multiplier.

Parameters:
- LATENCY, 2, number of CALC cycles the multiplier path is given (legal range 1..15).

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  synchronous active-low reset.
- start  in  1  request a multiply; sampled only in IDLE.
- is_signed  in  1  1 = MULT (two's complement), 0 = MULTU; sampled with start.
- src_a  in  32  multiplicand.
- src_b  in  32  multiplier.
- wr_hi  in  1  direct write of HI.
- wr_lo  in  1  direct write of LO.
- wr_data  in  32  data for wr_hi/wr_lo.
- mul_a  out  32  registered operand magnitude to the combinational multiplier.
- mul_b  out  32  registered operand magnitude to the combinational multiplier.
- mul_product  in  64  unsigned product returned by the combinational multiplier.
- busy  out  1  high while in CALC.
- done  out  1  one-cycle pulse; HI/LO hold the new result in the same cycle.
- hi  out  32  HI register.
- lo  out  32  LO register.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-low, resetn.
- Reset (resetn=0 at a rising edge):
  - state=IDLE, cnt=0, neg=0.
  - mul_a=0, mul_b=0, hi=0, lo=0, done=0, busy=0.
  - Overrides all other inputs. An in-flight multiply is abandoned: no HI/LO write, no done.
- States: IDLE, CALC. Encoding is two states in one bit; busy = (state==CALC).
- IDLE, start=1 at edge E0:
  - mul_a <= (is_signed & src_a[31]) ? -src_a : src_a; mul_b likewise for src_b.
  - neg <= is_signed & (src_a[31] ^ src_b[31]).
  - cnt <= LATENCY-1; state <= CALC.
- CALC:
  - Each edge with cnt!=0: cnt <= cnt-1.
  - At the edge with cnt==0: {hi,lo} <= neg ? (~mul_product + 1) : mul_product; done <= 1; state <= IDLE.
  - Result lands at edge E0+LATENCY; done is high for the following cycle only.
- done: deasserted on every edge that does not commit a result.
- Magnitude rules:
  - 0x80000000 under signed mode stays 0x80000000 and is treated as unsigned 2^31.
  - The 64-bit negate wraps modulo 2^64.
  - Unsigned operands pass through unchanged.
- start while busy: ignored; no queueing.
- start in the cycle done is high: state is IDLE, so it is accepted (back-to-back).
- wr_hi/wr_lo in IDLE: the register updates at the next edge. Both may be asserted together; both get wr_data.
- wr_hi/wr_lo in CALC: ignored; the commit wins.
- wr_* and start in the same IDLE cycle: the write is applied, the multiply starts, and the later commit overwrites HI/LO.
- mul_a/mul_b: hold their values after commit until the next accepted start.
- Zero operands: the product is 0 and neg is irrelevant, since negating 0 gives 0.

Decomposition:
- Shared package/header holds:
  - state encodings S_IDLE and S_CALC.
  - default LATENCY.
  - widths XLEN=32 and PLEN=64.
- One natural combinational sub-module, mul_sign_adjust:
  - 32-bit conditional absolute value on the input side.
  - 64-bit conditional negate on the output side.
- The FSM, counter and HI/LO registers stay in mul_hilo_ctrl. The combinational multiplier is instantiated beside it, not inside.

Test Plan:
1. LATENCY=2, MULTU 0xFFFFFFFF x 0xFFFFFFFF, start at E0 -> busy high after E0 and E1, HI=0xFFFFFFFE, LO=0x00000001 after E2, done high exactly one cycle.
2. MULT 0xFFFFFFFD (-3) x 0x00000005 -> mul_a=3, mul_b=5, HI=0xFFFFFFFF, LO=0xFFFFFFF1.
3. MULT 0x80000000 x 0x80000000 -> HI=0x40000000, LO=0. MULT 0x80000000 x 1 -> HI=0xFFFFFFFF, LO=0x80000000.
4. start pulsed again during CALC -> ignored, single done. start held through the done cycle with new operands 7x6 unsigned -> accepted, second done LATENCY+1 cycles later with LO=0x2A.
5. resetn=0 at E1 mid-CALC after HI/LO preloaded -> HI=LO=0, busy=0, done never asserts, next start works normally.
6. IDLE wr_hi with wr_data=0x12345678 -> HI=0x12345678 next edge. wr_lo=0xDEADBEEF during CALC -> ignored, LO equals the multiply result after commit.

Source files
------------

// File: rtl/mul_hilo_ctrl_pkg.sv
// Shared definitions for the multi-cycle HI/LO multiply control stage:
// data widths, state encoding and the default settle latency.
package mul_hilo_ctrl_pkg;

    localparam int unsigned XLEN            = 32;
    localparam int unsigned PLEN            = 64;
    localparam int unsigned LATENCY_DEFAULT = 2;
    localparam int unsigned CNT_W           = 4;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_CALC = 1'b1
    } state_e;

    // Operand magnitudes plus the deferred result sign, captured on start.
    typedef struct packed {
        logic [XLEN-1:0] mag_a;
        logic [XLEN-1:0] mag_b;
        logic            neg;
    } mul_req_t;

endpackage

// File: rtl/mul_sign_adjust.sv
// Sign handling around the unsigned multiplier: conditional absolute value
// of the operands on the way in, conditional 64-bit negate on the way out.
module mul_sign_adjust
    import mul_hilo_ctrl_pkg::*;
(
    input  logic            is_signed_i,
    input  logic [XLEN-1:0] src_a_i,
    input  logic [XLEN-1:0] src_b_i,
    input  logic            neg_i,
    input  logic [PLEN-1:0] product_i,
    output mul_req_t        req_c,
    output logic [PLEN-1:0] result_c
);

    logic a_neg;
    logic b_neg;

    assign a_neg = is_signed_i & src_a_i[XLEN-1];
    assign b_neg = is_signed_i & src_b_i[XLEN-1];

    // 0x80000000 negates to itself, which reads correctly as unsigned 2^31.
    always_comb begin
        req_c       = '0;
        req_c.mag_a = a_neg ? (~src_a_i + XLEN'(1)) : src_a_i;
        req_c.mag_b = b_neg ? (~src_b_i + XLEN'(1)) : src_b_i;
        req_c.neg   = a_neg ^ b_neg;
    end

    assign result_c = neg_i ? (~product_i + PLEN'(1)) : product_i;

endmodule

// File: rtl/mul_hilo_ctrl.sv
// Multi-cycle control around an external combinational 32x32 multiplier:
// captures operand magnitudes, waits LATENCY cycles, commits to HI/LO.
module mul_hilo_ctrl
    import mul_hilo_ctrl_pkg::*;
#(
    parameter int unsigned LATENCY = LATENCY_DEFAULT
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            start,
    input  logic            is_signed,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic            wr_hi,
    input  logic            wr_lo,
    input  logic [XLEN-1:0] wr_data,
    output logic [XLEN-1:0] mul_a,
    output logic [XLEN-1:0] mul_b,
    input  logic [PLEN-1:0] mul_product,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_e          state_q;
    logic [CNT_W-1:0] cnt_q;
    logic            neg_q;
    logic [XLEN-1:0] mul_a_q;
    logic [XLEN-1:0] mul_b_q;
    logic [XLEN-1:0] hi_q;
    logic [XLEN-1:0] lo_q;
    logic            done_q;

    mul_req_t        req;
    logic [PLEN-1:0] result;

    mul_sign_adjust u_sign_adjust (
        .is_signed_i (is_signed),
        .src_a_i     (src_a),
        .src_b_i     (src_b),
        .neg_i       (neg_q),
        .product_i   (mul_product),
        .req_c       (req),
        .result_c    (result)
    );

    // Reset abandons any in-flight multiply without touching HI/LO afterwards.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            mul_a_q <= '0;
            mul_b_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (wr_hi) begin
                        hi_q <= wr_data;
                    end
                    if (wr_lo) begin
                        lo_q <= wr_data;
                    end
                    if (start) begin
                        mul_a_q <= req.mag_a;
                        mul_b_q <= req.mag_b;
                        neg_q   <= req.neg;
                        cnt_q   <= CNT_LOAD;
                        state_q <= S_CALC;
                    end
                end
                S_CALC: begin
                    // Direct writes and new starts are ignored here; the commit wins.
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        hi_q    <= result[PLEN-1:XLEN];
                        lo_q    <= result[XLEN-1:0];
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign mul_a = mul_a_q;
    assign mul_b = mul_b_q;
    assign busy  = (state_q == S_CALC);
    assign done  = done_q;
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule
